// File: rtl/cluster_clock_switch_ctrl.sv
// rtl/cluster_clock_switch_ctrl.sv - glitch-free clock mux select sequencer
// Gates the cluster clock off, changes the mux select, lets it settle, then re-enables.
module cluster_clock_switch_ctrl #(
  parameter int unsigned OFF_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic sel_i,
  output logic ready_o,
  output logic busy_o,
  output logic done_o,
  output logic clk_sel_o,
  output logic clk_en_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SETTLE   = 2'd2
  } state_t;

  localparam logic [7:0] OFF_LOAD    = 8'(OFF_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       target_q, target_d;
  logic       sel_d, en_d, done_d, ready_d, busy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      clk_sel_o <= 1'b0;
      clk_en_o  <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      clk_sel_o <= sel_d;
      clk_en_o  <= en_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      ready_o   <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = clk_sel_o;
    en_d     = clk_en_o;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i && ready_o) begin
          target_d = sel_i;
          if (sel_i != clk_sel_o) begin
            state_d = GATE_OFF;
            cnt_d   = OFF_LOAD;
            en_d    = 1'b0;
          end else begin
            // Already on the requested clock: acknowledge without touching the gate.
            done_d = 1'b1;
          end
        end
      end
      GATE_OFF: begin
        if (cnt_q == 8'd0) begin
          sel_d   = target_q;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          en_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cluster_clock_switch_ctrl.sv
// tb/tb_cluster_clock_switch_ctrl.sv - directed self-checking bench for cluster_clock_switch_ctrl
module tb_cluster_clock_switch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, sel = 1'b0;
  logic ready, busy, done, clk_sel, clk_en;
  logic req2 = 1'b0, sel2 = 1'b0;
  logic ready2, busy2, done2, clk_sel2, clk_en2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cluster_clock_switch_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .sel_i(sel),
    .ready_o(ready), .busy_o(busy), .done_o(done),
    .clk_sel_o(clk_sel), .clk_en_o(clk_en)
  );

  cluster_clock_switch_ctrl #(.OFF_CYCLES(1), .SETTLE_CYCLES(1)) u_fast (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .sel_i(sel2),
    .ready_o(ready2), .busy_o(busy2), .done_o(done2),
    .clk_sel_o(clk_sel2), .clk_en_o(clk_en2)
  );

  // Select may only move while the gate is off both before and after the change.
  logic mon_valid = 1'b0;
  logic p_rst, p_sel, p_en, p_sel2, p_en2;
  int   inv_viol = 0;
  always @(negedge clk) begin
    if (mon_valid && !p_rst) begin
      if (clk_sel !== p_sel && (p_en !== 1'b0 || clk_en !== 1'b0))
        inv_viol <= inv_viol + 1;
      else if (clk_sel2 !== p_sel2 && (p_en2 !== 1'b0 || clk_en2 !== 1'b0))
        inv_viol <= inv_viol + 1;
    end
    mon_valid <= 1'b1;
    p_rst  <= rst;
    p_sel  <= clk_sel;
    p_en   <= clk_en;
    p_sel2 <= clk_sel2;
    p_en2  <= clk_en2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic e_busy,
                         input logic e_done, input logic e_sel, input logic e_en);
    chk({tag, ".ready"}, ready, e_ready);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".sel"}, clk_sel, e_sel);
    chk({tag, ".en"}, clk_en, e_en);
  endtask

  task automatic chk_fast(input string tag, input logic e_ready, input logic e_busy,
                          input logic e_done, input logic e_sel, input logic e_en);
    chk({tag, ".ready"}, ready2, e_ready);
    chk({tag, ".busy"}, busy2, e_busy);
    chk({tag, ".done"}, done2, e_done);
    chk({tag, ".sel"}, clk_sel2, e_sel);
    chk({tag, ".en"}, clk_en2, e_en);
  endtask

  initial begin
    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_all("reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_fast("reset_idle_fast", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end

    // 0 -> 1 switch with default timing.
    req = 1'b1; sel = 1'b1;
    step();
    req = 1'b0; sel = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk_all($sformatf("sw01_T%0d", k), (k >= 9), (k <= 8), (k == 9), (k >= 5), (k >= 9));
      step();
    end

    // Request for the already-selected clock.
    req = 1'b1; sel = 1'b1;
    step();
    req = 1'b0;
    chk_all("same_T1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("same_T2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // 1 -> 0 switch with noise while busy, then re-request in the done cycle.
    req = 1'b1; sel = 1'b0;
    step();
    req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk_all($sformatf("sw10_T%0d", k), (k >= 9), (k <= 8), (k == 9), (k < 5), (k >= 9));
      if (k >= 2 && k <= 7) begin
        req = k[0];
        sel = ~k[0];
      end else if (k == 8) begin
        req = 1'b0;
      end else if (k == 9) begin
        req = 1'b1;
        sel = 1'b1;
      end
      step();
    end
    req = 1'b0; sel = 1'b0;
    chk_all("rereq_T10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) step();
    chk_all("rereq_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();

    // Reset in the middle of a 0 -> 1 switch.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("pre_mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    req = 1'b1; sel = 1'b1;
    step();
    req = 1'b0;
    chk_all("midrst_T1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("midrst_T4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 5; k <= 12; k++) begin
      chk_all($sformatf("midrst_T%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end

    // Minimum-length sequence on the 1/1 instance.
    req2 = 1'b1; sel2 = 1'b1;
    step();
    req2 = 1'b0; sel2 = 1'b0;
    chk_fast("fast_T1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_fast("fast_T2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_fast("fast_T3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_fast("fast_T4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    n_checks++;
    assert (inv_viol === 0)
    else begin
      n_fail++;
      $error("FAIL sel_while_enabled observed=%0d expected=0", inv_viol);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_clock_switch_ctrl.md
Name: cluster_clock_switch_ctrl

Overview:
- Sequencer that drives the select and enable of a downstream 2-input cluster clock mux and clock gate.
- Switching the mux select while the output clock is live can glitch. This block therefore accepts a switch request, gates the clock off, waits, changes the select, waits for settling, then re-enables the clock and signals completion.
- Runs on a single always-on reference clock and sits between the SoC control registers and the cluster clock mux/gate pair.

Parameters:
- OFF_CYCLES, 4, cycles clk_en_o is held low before clk_sel_o changes; legal range 1..255.
- SETTLE_CYCLES, 4, cycles clk_sel_o is held at the new value, with clk_en_o still low, before re-enable; legal range 1..255.

Ports:
- clk_i  input  1  always-on reference clock; all logic is on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  switch request; accepted in any cycle where req_i && ready_o.
- sel_i  input  1  target mux select; sampled only on acceptance.
- ready_o  output  1  high only in IDLE.
- busy_o  output  1  high while a switch sequence is in progress.
- done_o  output  1  one-cycle pulse marking the end of the sequence.
- clk_sel_o  output  1  select to the clock mux (0 = clk0, 1 = clk1).
- clk_en_o  output  1  enable to the downstream clock gate.

Behaviour:
- All outputs are registered.
- Reset values: clk_sel_o=0, clk_en_o=1, busy_o=0, done_o=0, ready_o=1, state=IDLE, counter=0.
- FSM states are IDLE, GATE_OFF and SETTLE.
  - IDLE: ready_o=1, busy_o=0. On acceptance, sel_i is latched as the target.
    - Target differs from clk_sel_o: go to GATE_OFF, load counter with OFF_CYCLES-1, clk_en_o←0, busy_o←1, ready_o←0.
    - Target equals clk_sel_o: stay in IDLE; done_o←1 for the next cycle only; clk_en_o and clk_sel_o are unchanged.
  - GATE_OFF: counter decrements each cycle.
    - At counter==0: clk_sel_o←target, load counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: counter decrements each cycle.
    - At counter==0: clk_en_o←1, done_o←1, busy_o←0, ready_o←1, go to IDLE.
- done_o is high for exactly one cycle and is otherwise 0.
- Timing for a request accepted at edge T (default parameters):
  - clk_en_o=0 in cycles T+1..T+OFF+SETTLE, i.e. 8 cycles.
  - clk_sel_o changes at T+OFF+1 = T+5.
  - clk_en_o=1, done_o=1 and ready_o=1 at T+OFF+SETTLE+1 = T+9.
- Invariant: clk_sel_o never changes in a cycle where clk_en_o=1, and never in the same cycle that clk_en_o changes.
- Requests arriving while ready_o=0 are ignored and not queued; sel_i changes while busy have no effect.
- A new request can be accepted in the same cycle that done_o is high, since ready_o is also high in that cycle.
- Counter width is 8 bits with no wrap-around: the counter is always loaded before use and stops at 0.
- Reset mid-sequence: at the next edge with rst_i=1, all outputs return to their reset values (clk_sel_o=0, clk_en_o=1), regardless of state. No done_o pulse is generated.
- rst_i has priority over req_i in the same cycle.

Test Plan:
- Reset, then idle for 5 cycles -> clk_sel_o=0, clk_en_o=1, ready_o=1, busy_o=0, done_o=0 throughout.
- req_i=1, sel_i=1 at T (defaults) -> clk_en_o=0 at T+1..T+8; clk_sel_o=1 from T+5; clk_en_o=1, done_o=1 at T+9; done_o=0 at T+10.
- req_i=1, sel_i=1 while clk_sel_o=1 -> done_o=1 at T+1 only; clk_en_o stays 1; busy_o stays 0.
- Start a 1→0 switch, toggle req_i/sel_i during T+2..T+7, then re-request 1 in the done_o cycle -> the first sequence completes unchanged with clk_sel_o=0 at T+5; the second request is accepted and clk_en_o=0 at T+10.
- rst_i=1 at T+3 of a 0→1 switch -> at T+4, clk_en_o=1, clk_sel_o=0, ready_o=1, with no done_o pulse.
- OFF_CYCLES=1, SETTLE_CYCLES=1 -> clk_en_o low only at T+1..T+2, clk_sel_o changes at T+2, done_o at T+3; an assertion checks clk_sel_o is never toggled while clk_en_o=1.
